// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU (en/fin handshake) among N_REQ requesters.
// Latches the winner's operands, sequences the ALU handshake and returns result, id and a done pulse.
module alu_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  req_op,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [31:0]         rsp_result,
    output logic [ID_W-1:0]     rsp_id,
    output logic                rsp_err,
    output logic                busy,
    output logic                alu_en,
    output logic [1:0]          alu_ctrl,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_result,
    input  logic                alu_fin
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter is compared one short of TIMEOUT: the abort happens on the edge it would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur;
    logic [ID_W-1:0]   win;
    logic [N_REQ-1:0]  win_hot;
    logic [N_REQ-1:0]  cur_hot;
    logic [CNT_W-1:0]  cnt;
    logic              do_grant;
    logic              do_finish;
    logic              do_abort;
    logic [1:0]        sel_op;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;

    // First set request bit at or above p, wrapping from N_REQ-1 back to 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(p) + i) % N_REQ);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    assign win     = rr_pick(req, ptr);
    assign win_hot = N_REQ'(1) << win;
    assign cur_hot = N_REQ'(1) << cur;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_finish = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if ((|req) && alu_fin) begin
                    do_grant  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!alu_fin) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    do_abort  = 1'b1;
                    state_nxt = RESP;
                end
            end
            WAIT_DONE: begin
                // Completion is checked first so a finish on the timeout edge is not lost.
                if (alu_fin) begin
                    do_finish = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    do_abort  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            cur        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            alu_en     <= 1'b0;
            alu_ctrl   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            gnt    <= do_grant ? win_hot : '0;
            done   <= (do_finish || do_abort) ? cur_hot : '0;
            busy   <= (state_nxt != IDLE);
            alu_en <= (state_nxt == ISSUE) || (state_nxt == WAIT_BUSY);

            // Every phase change restarts the wait budget.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
                cnt <= cnt + 1'b1;
            end

            if (do_grant) begin
                cur      <= win;
                alu_ctrl <= sel_op;
                alu_a    <= sel_a;
                alu_b    <= sel_b;
            end

            if (do_finish) begin
                rsp_result <= alu_result;
                rsp_id     <= cur;
                rsp_err    <= 1'b0;
            end else if (do_abort) begin
                rsp_result <= '0;
                rsp_id     <= cur;
                rsp_err    <= 1'b1;
            end

            if (state == RESP) ptr <= next_id(cur);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural multi-cycle ALU model.
module tb_alu_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     rsp_result;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_err;
    logic            busy;
    logic            alu_en;
    logic [1:0]      alu_ctrl;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_result;
    logic            alu_fin;

    int total = 0;
    int bad   = 0;

    // ALU model configuration (written only by the stimulus block)
    logic stuck;
    int   drop_dly;
    int   calc_dly;

    // ALU model state
    int          m_state;
    int          m_cnt;
    logic [1:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        en_drop;

    alu_share_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_fin(alu_fin)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // ALU: drops fin drop_dly cycles after seeing en, raises fin with the result calc_dly cycles later.
    always @(posedge clk) begin
        if (rst) begin
            alu_fin    <= 1'b1;
            alu_result <= '0;
            m_state    <= 0;
            m_cnt      <= 0;
            en_drop    <= 1'b0;
        end else if (stuck) begin
            alu_fin <= 1'b1;
            m_state <= 0;
        end else begin
            case (m_state)
                0: if (alu_en && alu_fin) begin
                    m_op <= alu_ctrl;
                    m_a  <= alu_a;
                    m_b  <= alu_b;
                    if (drop_dly <= 1) begin
                        alu_fin <= 1'b0;
                        m_state <= 2;
                        m_cnt   <= calc_dly;
                    end else begin
                        m_state <= 1;
                        m_cnt   <= drop_dly - 1;
                    end
                end
                1: begin
                    if (!alu_en) en_drop <= 1'b1;
                    if (m_cnt <= 1) begin
                        alu_fin <= 1'b0;
                        m_state <= 2;
                        m_cnt   <= calc_dly;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (m_cnt <= 1) begin
                        alu_fin    <= 1'b1;
                        alu_result <= alu_calc(m_op, m_a, m_b);
                        m_state    <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int order [4] = '{0, 1, 3, 0};

        rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0;
        stuck = 1'b0; drop_dly = 1; calc_dly = 1;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(alu_en), 0);
        chk("rst_result", rsp_result, 0);
        rst = 1'b0;
        tick();

        // Single add, ALU latency 1
        set_req(0, 2'b00, 5, 3);
        req = 4'b0001;
        wait_gnt(n);
        chk("add_gnt", 32'(gnt), 32'b0001);
        chk("add_gnt_lat", n, 1);
        chk("add_en0", 32'(alu_en), 1);
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 3);
        chk("add_busy", 32'(busy), 1);
        req = '0;
        tick();
        chk("add_gnt_pulse", 32'(gnt), 0);
        chk("add_en1", 32'(alu_en), 1);
        tick();
        chk("add_en_off", 32'(alu_en), 0);
        tick();
        chk("add_done", 32'(done), 32'b0001);
        chk("add_result", rsp_result, 8);
        chk("add_id", 32'(rsp_id), 0);
        chk("add_err", 32'(rsp_err), 0);
        tick();
        chk("add_done_pulse", 32'(done), 0);
        chk("add_idle", 32'(busy), 0);

        // Contention with pointer back at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 10, 4);
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            chk("rr_gnt", 32'(gnt), 32'(1) << order[k]);
            if (k == 3) req = '0;
            wait_done(n);
            chk("rr_done", 32'(done), 32'(1) << order[k]);
            chk("rr_result", rsp_result, 6);
            chk("rr_id", 32'(rsp_id), order[k]);
            chk("rr_err", 32'(rsp_err), 0);
        end

        // Divide: fin drops 3 cycles after en rises
        drop_dly = 3; calc_dly = 2;
        set_req(2, 2'b11, 32'h2468, 2);
        req = 4'b0100;
        wait_gnt(n);
        chk("div_gnt", 32'(gnt), 32'b0100);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("div_en_hold", 32'(alu_en), 1);
        end
        tick();
        chk("div_en_off", 32'(alu_en), 0);
        wait_done(n);
        chk("div_done", 32'(done), 32'b0100);
        chk("div_result", rsp_result, 32'h0000_1234);
        chk("div_id", 32'(rsp_id), 2);
        chk("div_en_early_drop", 32'(en_drop), 0);
        tick();
        chk("div_done_pulse", 32'(done), 0);

        // Timeout in WAIT_BUSY: ALU never leaves idle
        stuck = 1'b1; drop_dly = 1; calc_dly = 1;
        set_req(1, 2'b00, 1, 1);
        req = 4'b0010;
        wait_gnt(n);
        chk("to_gnt", 32'(gnt), 32'b0010);
        req = '0;
        wait_done(n);
        chk("to_cycles", n, 9);
        chk("to_done", 32'(done), 32'b0010);
        chk("to_err", 32'(rsp_err), 1);
        chk("to_result", rsp_result, 0);
        chk("to_id", 32'(rsp_id), 1);
        chk("to_en", 32'(alu_en), 0);
        stuck = 1'b0;
        set_req(0, 2'b00, 7, 1);
        req = 4'b0001;
        wait_gnt(n);
        chk("after_to_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wait_done(n);
        chk("after_to_cycles", n, 3);
        chk("after_to_result", rsp_result, 8);
        chk("after_to_err", 32'(rsp_err), 0);

        // Reset during WAIT_DONE
        calc_dly = 20;
        set_req(0, 2'b00, 5, 5);
        req = 4'b0001;
        wait_gnt(n);
        chk("mid_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 1);
        chk("mid_en", 32'(alu_en), 0);
        calc_dly = 1;
        set_req(3, 2'b10, 6, 7);
        req = 4'b1000;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ab", alu_a | alu_b, 0);
        chk("mid_rst_ctrl_gnt", {alu_ctrl, gnt, done, 22'(rsp_id), alu_en, rsp_err}, 0);
        tick();
        chk("mid_rst_nodone", 32'(done), 0);
        rst = 1'b0;
        wait_gnt(n);
        chk("mid_post_gnt", 32'(gnt), 32'b1000);
        req = '0;
        wait_done(n);
        chk("mid_post_done", 32'(done), 32'b1000);
        chk("mid_post_result", rsp_result, 42);
        chk("mid_post_id", 32'(rsp_id), 3);

        // Completion on the timeout edge wins
        calc_dly = 8;
        set_req(1, 2'b01, 100, 1);
        req = 4'b0010;
        wait_gnt(n);
        chk("tie_gnt", 32'(gnt), 32'b0010);
        req = '0;
        wait_done(n);
        chk("tie_cycles", n, 10);
        chk("tie_done", 32'(done), 32'b0010);
        chk("tie_err", 32'(rsp_err), 0);
        chk("tie_result", rsp_result, 99);

        // One cycle later the timeout wins in WAIT_DONE
        calc_dly = 9;
        req = 4'b0010;
        wait_gnt(n);
        chk("late_gnt", 32'(gnt), 32'b0010);
        req = '0;
        wait_done(n);
        chk("late_cycles", n, 10);
        chk("late_err", 32'(rsp_err), 1);
        chk("late_result", rsp_result, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
